// File: rtl/pc_sequencer_if.sv
// Purpose: groups the pc_sequencer control inputs and fetch-address outputs into one bundle.
// Ports: master = pipeline/hazard side (drives stall/redirect/exc/eret/call/ret, reads PCs);
//        slave = pc_sequencer (consumes controls, drives pc_out/epc_out/adel_pulse/ras_count).
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
);
    logic                        stall;
    logic                        redirect_valid;
    logic [ADDR_WIDTH-1:0]       redirect_target;
    logic                        exc_valid;
    logic [ADDR_WIDTH-1:0]       exc_pc;
    logic                        eret_valid;
    logic                        call_valid;
    logic [ADDR_WIDTH-1:0]       call_target;
    logic                        ret_valid;
    logic [ADDR_WIDTH-1:0]       pc_out;
    logic [ADDR_WIDTH-1:0]       epc_out;
    logic                        adel_pulse;
    logic [$clog2(RAS_DEPTH):0]  ras_count;

    modport master (
        output stall, redirect_valid, redirect_target, exc_valid, exc_pc,
               eret_valid, call_valid, call_target, ret_valid,
        input  pc_out, epc_out, adel_pulse, ras_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, exc_valid, exc_pc,
               eret_valid, call_valid, call_target, ret_valid,
        output pc_out, epc_out, adel_pulse, ras_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: IF-stage next-PC selection (exception, misaligned redirect, eret, redirect,
//          stall, call, return, sequential) with EPC register and optional return-address stack.
// Ports: clk, reset (async, active-high), bus (pc_sequencer_if.slave). All outputs registered,
//        1-cycle latency. Optional RAS enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]           EXC_VECTOR   = 32'h0000_0180,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int                    PTR_W    = $clog2(RAS_DEPTH);
    localparam int                    CNT_W    = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] EXC_ADDR = ADDR_WIDTH'(EXC_VECTOR);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic                  adel_q, adel_d;
    logic                  misaligned;

    assign misaligned = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

`ifdef PC_SEQUENCER_RAS_EN
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_q, ptr_d;   // next write slot; top of stack is ptr_q-1
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] push_val;
    logic [ADDR_WIDTH-1:0] ras_top;

    assign ras_top  = ras_q[ptr_q - PTR_W'(1)];
    // Return lands past the delay slot of the call.
    assign push_val = pc_q + ADDR_WIDTH'(8);
`endif

    always_comb begin
        pc_d   = pc_q;
        epc_d  = epc_q;
        adel_d = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
        push   = 1'b0;
        pop    = 1'b0;
`endif
        if (bus.exc_valid) begin
            pc_d  = EXC_ADDR;
            epc_d = bus.exc_pc;
        end else if (misaligned) begin
            // Address-error on fetch target: vector to handler, record the bad target.
            pc_d   = EXC_ADDR;
            epc_d  = bus.redirect_target;
            adel_d = 1'b1;
        end else if (bus.eret_valid) begin
            pc_d = epc_q;
        end else if (bus.redirect_valid) begin
            pc_d = bus.redirect_target;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.call_valid) begin
            pc_d = bus.call_target;
`ifdef PC_SEQUENCER_RAS_EN
            push = 1'b1;
`endif
        end else if (bus.ret_valid) begin
`ifdef PC_SEQUENCER_RAS_EN
            if (cnt_q != '0) begin
                pc_d = ras_top;
                pop  = 1'b1;
            end else begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
`else
            pc_d = pc_q + ADDR_WIDTH'(4);
`endif
        end else begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_VECTOR;
            epc_q  <= '0;
            adel_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            epc_q  <= epc_d;
            adel_q <= adel_d;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            // Circular: a push when full overwrites the oldest entry.
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (push) begin
                ras_q[ptr_q] <= push_val;
            end
        end
    end

    assign bus.ras_count = cnt_q;
`else
    assign bus.ras_count = {CNT_W{1'b0}};
`endif

    assign bus.pc_out     = pc_q;
    assign bus.epc_out    = epc_q;
    assign bus.adel_pulse = adel_q;
endmodule
